input_vc_ctrl: RTL

//  Per-VC controller directly downstream of input_buffer in the input port. Reads the head-of-queue

---
 rtl/input_vc_ctrl.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/input_vc_ctrl.sv
// Per-VC input controller: XY route computation, downstream VC allocation and
// credit-gated switch allocation for the flit at the head of input_buffer.
package input_vc_pkg;
    localparam int VC_SIZE = 2;
    localparam int DEST_W  = 4;
    localparam int DATA_W  = 16;

    typedef enum logic [1:0] {HEAD = 2'd0, BODY = 2'd1, TAIL = 2'd2, HEADTAIL = 2'd3} flit_label_t;
    typedef enum logic [2:0] {LOCAL = 3'd0, NORTH = 3'd1, SOUTH = 3'd2, WEST = 3'd3, EAST = 3'd4} port_t;
    typedef enum logic [1:0] {IDLE = 2'd0, RC = 2'd1, VA = 2'd2, SA = 2'd3} vc_state_t;

    typedef struct packed {
        flit_label_t         flit_label;
        logic [VC_SIZE-1:0]  vc_id;
        logic [DEST_W-1:0]   x_dest;
        logic [DEST_W-1:0]   y_dest;
        logic [DATA_W-1:0]   data;
    } flit_t;
endpackage

module input_vc_ctrl
    import input_vc_pkg::*;
#(
    parameter int X_CURRENT        = 0,
    parameter int Y_CURRENT        = 0,
    parameter int VC_NUM           = 2,
    parameter int DOWN_BUFFER_SIZE = 8,
    localparam int VC_W   = (VC_NUM > 1) ? $clog2(VC_NUM) : 1,
    localparam int CRED_W = $clog2(DOWN_BUFFER_SIZE + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  flit_t             flit_i,
    input  logic              buf_empty_i,
    output logic              buf_read_o,
    output logic              va_req_o,
    output port_t             va_port_o,
    input  logic              va_grant_i,
    input  logic [VC_W-1:0]   va_vc_i,
    output logic              sa_req_o,
    output port_t             sa_port_o,
    input  logic              sa_grant_i,
    input  logic              credit_i,
    output flit_t             flit_o,
    output logic              flit_valid_o,
    output logic              vc_release_o,
    output logic              error_o,
    output vc_state_t         state_o,
    output logic [CRED_W-1:0] credits_o
);
    // Handshakes: va_req_o/sa_req_o are level requests; a grant is honoured only
    // in a cycle where its request is high, and an SA grant pops the buffer in
    // that same cycle while the forwarded flit appears registered one cycle later.

    vc_state_t         state, next_state;
    port_t             route, route_calc;
    logic [VC_W-1:0]   out_vc;
    logic [CRED_W-1:0] credits;
    logic              head_sent;
    logic              is_head, is_last, cred_full;
    logic              va_fire, sa_fire, drop;
    flit_t             fwd_flit;

    assign is_head   = flit_i.flit_label inside {HEAD, HEADTAIL};
    assign is_last   = flit_i.flit_label inside {TAIL, HEADTAIL};
    assign cred_full = (credits == CRED_W'(DOWN_BUFFER_SIZE));

    assign va_port_o = route;
    assign sa_port_o = route;
    assign state_o   = state;
    assign credits_o = credits;

    always_comb begin
        route_calc = LOCAL;
        if (int'(flit_i.x_dest) > X_CURRENT)      route_calc = EAST;
        else if (int'(flit_i.x_dest) < X_CURRENT) route_calc = WEST;
        else if (int'(flit_i.y_dest) > Y_CURRENT) route_calc = SOUTH;
        else if (int'(flit_i.y_dest) < Y_CURRENT) route_calc = NORTH;
    end

    always_comb begin
        fwd_flit       = flit_i;
        fwd_flit.vc_id = VC_SIZE'(out_vc);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Request/pop outputs are forced low while reset is held so nothing is popped.
    always_comb begin
        next_state = state;
        va_req_o   = 1'b0;
        sa_req_o   = 1'b0;
        buf_read_o = 1'b0;
        va_fire    = 1'b0;
        sa_fire    = 1'b0;
        drop       = 1'b0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (!buf_empty_i) begin
                        if (is_head) begin
                            next_state = RC;
                        end else begin
                            drop       = 1'b1;
                            buf_read_o = 1'b1;
                        end
                    end
                end
                RC: next_state = VA;
                VA: begin
                    va_req_o = 1'b1;
                    if (va_grant_i) begin
                        va_fire    = 1'b1;
                        next_state = SA;
                    end
                end
                SA: begin
                    sa_req_o   = !buf_empty_i && (credits != '0);
                    sa_fire    = sa_req_o && sa_grant_i;
                    buf_read_o = sa_fire;
                    if (sa_fire && is_last) next_state = IDLE;
                end
                default: next_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            route        <= LOCAL;
            out_vc       <= '0;
            credits      <= '0;
            head_sent    <= 1'b0;
            flit_o       <= '0;
            flit_valid_o <= 1'b0;
            vc_release_o <= 1'b0;
            error_o      <= 1'b0;
        end else begin
            flit_valid_o <= sa_fire;
            vc_release_o <= sa_fire && is_last;
            if (sa_fire) flit_o <= fwd_flit;
            if (state == RC) route <= route_calc;
            if (drop) error_o <= 1'b1;
            if (va_fire) begin
                out_vc    <= va_vc_i;
                credits   <= CRED_W'(DOWN_BUFFER_SIZE);
                head_sent <= 1'b0;
            end
            // A returned credit and a granted flit in the same cycle cancel out.
            if (state == SA) begin
                if (credit_i && !sa_fire) begin
                    if (cred_full) error_o <= 1'b1;
                    else           credits <= credits + CRED_W'(1);
                end else if (!credit_i && sa_fire) begin
                    credits <= credits - CRED_W'(1);
                end
                if (sa_fire) begin
                    head_sent <= 1'b1;
                    if (is_head && head_sent) error_o <= 1'b1;
                end
            end
        end
    end
endmodule
